// File: rtl/decode.sv
// RV32I decode stage: latches the fetched word and PC on the start pulse, decodes it,
// reads rs1/rs2 through the register file and holds the results for execute.
module decode #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enabled,
    input  logic [XLEN-1:0]       pc,
    input  logic [31:0]           instr_raw,
    output logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    output logic                  completed,
    output logic [XLEN-1:0]       pc_n,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [2:0]            funct3,
    output logic                  funct7_b5,
    output logic [XLEN-1:0]       imm,
    output logic [XLEN-1:0]       rs1_val,
    output logic [XLEN-1:0]       rs2_val,
    output logic [10:0]           instr_class,
    output logic                  is_auipc,
    output logic                  writes_rd
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_CAPTURE, S_DONE} state_t;

    state_t                r_state, w_state_next;
    logic [31:0]           r_instr;
    logic [XLEN-1:0]       r_pc;
    logic                  r_done;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [2:0]            r_funct3;
    logic                  r_funct7_b5;
    logic [XLEN-1:0]       r_imm;
    logic [XLEN-1:0]       r_rs1_val;
    logic [XLEN-1:0]       r_rs2_val;
    logic [10:0]           r_class;
    logic                  r_is_auipc;
    logic                  r_writes_rd;

    logic                  w_load;
    logic                  w_capture;
    logic [10:0]           w_class;
    logic                  w_is_auipc;
    logic [XLEN-1:0]       w_imm;
    logic                  w_writes_rd;
    logic [6:0]            w_opcode;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (enabled) begin
            w_state_next = S_READ;
        end else begin
            case (r_state)
                S_READ:    w_state_next = S_CAPTURE;
                S_CAPTURE: w_state_next = S_DONE;
                default:   w_state_next = r_state;
            endcase
        end
    end

    // A new start pulse pre-empts any load/capture of the abandoned operation.
    always_comb begin
        w_load    = (r_state == S_READ) && !enabled;
        w_capture = (r_state == S_CAPTURE) && !enabled;
    end

    assign w_opcode = r_instr[6:0];

    // instr_class bit order: {illegal,system,fence,alu_r,alu_i,store,load,branch,jalr,jal,lui/auipc}
    always_comb begin
        w_class    = 11'b0;
        w_is_auipc = 1'b0;
        w_imm      = '0;
        case (w_opcode)
            7'b0110111: begin w_class[0] = 1'b1; w_imm = XLEN'($signed({r_instr[31:12], 12'b0})); end
            7'b0010111: begin
                w_class[0] = 1'b1;
                w_is_auipc = 1'b1;
                w_imm      = XLEN'($signed({r_instr[31:12], 12'b0}));
            end
            7'b1101111: begin
                w_class[1] = 1'b1;
                w_imm = XLEN'($signed({r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0}));
            end
            7'b1100111: begin w_class[2] = 1'b1; w_imm = XLEN'($signed(r_instr[31:20])); end
            7'b1100011: begin
                w_class[3] = 1'b1;
                w_imm = XLEN'($signed({r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0}));
            end
            7'b0000011: begin w_class[4] = 1'b1; w_imm = XLEN'($signed(r_instr[31:20])); end
            7'b0100011: begin w_class[5] = 1'b1; w_imm = XLEN'($signed({r_instr[31:25], r_instr[11:7]})); end
            7'b0010011: begin
                w_class[6] = 1'b1;
                if (r_instr[13:12] == 2'b01) w_imm = XLEN'(r_instr[24:20]);
                else                         w_imm = XLEN'($signed(r_instr[31:20]));
            end
            7'b0110011: w_class[7] = 1'b1;
            7'b0001111: w_class[8] = 1'b1;
            7'b1110011: w_class[9] = 1'b1;
            default:    w_class[10] = 1'b1;
        endcase
        w_writes_rd = (w_class[0] | w_class[1] | w_class[2] | w_class[4] | w_class[6] | w_class[7])
                      && (r_instr[11:7] != 5'd0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_instr     <= '0;
            r_pc        <= '0;
            r_done      <= 1'b0;
            r_rd        <= '0;
            r_funct3    <= '0;
            r_funct7_b5 <= 1'b0;
            r_imm       <= '0;
            r_rs1_val   <= '0;
            r_rs2_val   <= '0;
            r_class     <= '0;
            r_is_auipc  <= 1'b0;
            r_writes_rd <= 1'b0;
        end else begin
            if (enabled) begin
                r_instr <= instr_raw;
                r_pc    <= pc;
                r_done  <= 1'b0;
            end
            if (w_load) begin
                r_rd        <= r_instr[11:7];
                r_funct3    <= r_instr[14:12];
                r_funct7_b5 <= r_instr[30];
                r_imm       <= w_imm;
                r_class     <= w_class;
                r_is_auipc  <= w_is_auipc;
                r_writes_rd <= w_writes_rd;
            end
            if (w_capture) begin
                r_rs1_val <= rs1_data;
                r_rs2_val <= rs2_data;
                r_done    <= 1'b1;
            end
        end
    end

    assign rs1_addr    = r_instr[19:15];
    assign rs2_addr    = r_instr[24:20];
    assign completed   = r_done & ~enabled;
    assign pc_n        = r_pc;
    assign rd          = r_rd;
    assign funct3      = r_funct3;
    assign funct7_b5   = r_funct7_b5;
    assign imm         = r_imm;
    assign rs1_val     = r_rs1_val;
    assign rs2_val     = r_rs2_val;
    assign instr_class = r_class;
    assign is_auipc    = r_is_auipc;
    assign writes_rd   = r_writes_rd;

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage: hand-decoded RV32I words, handshake timing,
// mid-operation reset and re-enable.
module tb_decode;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enabled;
    logic [31:0] pc;
    logic [31:0] instr_raw;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        completed;
    logic [31:0] pc_n;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [31:0] imm, rs1_val, rs2_val;
    logic [10:0] instr_class;
    logic        is_auipc;
    logic        writes_rd;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    decode dut (
        .clk(clk), .rstn(rstn), .enabled(enabled), .pc(pc), .instr_raw(instr_raw),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .completed(completed), .pc_n(pc_n), .rd(rd), .funct3(funct3), .funct7_b5(funct7_b5),
        .imm(imm), .rs1_val(rs1_val), .rs2_val(rs2_val), .instr_class(instr_class),
        .is_auipc(is_auipc), .writes_rd(writes_rd)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Pulse enabled for one cycle; returns at the following negedge with enabled low.
    task automatic issue(input logic [31:0] w, input logic [31:0] p,
                         input logic [31:0] d1, input logic [31:0] d2);
        @(negedge clk);
        instr_raw = w; pc = p; rs1_data = d1; rs2_data = d2; enabled = 1'b1;
        #1 check_val("completed_masked", 32'(completed), 32'd0);
        @(negedge clk);
        enabled = 1'b0;
    endtask

    // Completion must appear exactly two edges after the sampling edge.
    task automatic wait_done(input string tag);
        #1 check_val({tag, "_c1"}, 32'(completed), 32'd0);
        @(negedge clk);
        check_val({tag, "_c2"}, 32'(completed), 32'd0);
        @(negedge clk);
        check_val({tag, "_c3"}, 32'(completed), 32'd1);
        $display("op %s instr=0x%08h pc_n=0x%08h rd=%0d imm=0x%08h class=0x%03h wr=%0d",
                 tag, instr_raw, pc_n, rd, imm, instr_class, writes_rd);
    endtask

    initial begin
        rstn = 1'b0; enabled = 1'b0; pc = '0; instr_raw = '0; rs1_data = '0; rs2_data = '0;
        #12;
        check_val("rst_completed", 32'(completed), 32'd0);
        check_val("rst_imm", imm, 32'd0);
        check_val("rst_class", 32'(instr_class), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Reset mid-operation: beq has rs1=1 and pc_n is already latched
        issue(32'hFE208EE3, 32'h0000_0100, 32'd7, 32'd9);
        check_val("midrst_pc_pre", pc_n, 32'h0000_0100);
        rstn = 1'b0;
        #1;
        check_val("midrst_pc_n", pc_n, 32'd0);
        check_val("midrst_rs1_addr", 32'(rs1_addr), 32'd0);
        check_val("midrst_rs2_addr", 32'(rs2_addr), 32'd0);
        check_val("midrst_completed", 32'(completed), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("postrst_completed", 32'(completed), 32'd0);
        end
        $display("op reset_mid_op done");

        // addi x1,x0,5
        issue(32'h00500093, 32'h0000_0200, 32'd0, 32'd0);
        wait_done("addi");
        check_val("addi_rd", 32'(rd), 32'd1);
        check_val("addi_imm", imm, 32'd5);
        check_val("addi_class", 32'(instr_class), 32'h040);
        check_val("addi_wr", 32'(writes_rd), 32'd1);
        check_val("addi_rs1_addr", 32'(rs1_addr), 32'd0);
        check_val("addi_pc_n", pc_n, 32'h0000_0200);
        @(negedge clk);
        check_val("addi_hold", 32'(completed), 32'd1);

        // lui x5,0x12345
        issue(32'h123452B7, 32'h0000_0204, 32'd0, 32'd0);
        wait_done("lui");
        check_val("lui_imm", imm, 32'h12345000);
        check_val("lui_rd", 32'(rd), 32'd5);
        check_val("lui_class", 32'(instr_class), 32'h001);
        check_val("lui_auipc", 32'(is_auipc), 32'd0);
        check_val("lui_wr", 32'(writes_rd), 32'd1);

        // beq x1,x2,-4
        issue(32'hFE208EE3, 32'h0000_0208, 32'd7, 32'd9);
        wait_done("beq");
        check_val("beq_imm", imm, 32'hFFFF_FFFC);
        check_val("beq_class", 32'(instr_class), 32'h008);
        check_val("beq_rs1_val", rs1_val, 32'd7);
        check_val("beq_rs2_val", rs2_val, 32'd9);
        check_val("beq_wr", 32'(writes_rd), 32'd0);
        check_val("beq_rs1_addr", 32'(rs1_addr), 32'd1);
        check_val("beq_rs2_addr", 32'(rs2_addr), 32'd2);

        // sw x2,-8(x1)
        issue(32'hFE20AC23, 32'h0000_020C, 32'd0, 32'd0);
        wait_done("sw");
        check_val("sw_imm", imm, 32'hFFFF_FFF8);
        check_val("sw_class", 32'(instr_class), 32'h020);
        check_val("sw_funct3", 32'(funct3), 32'd2);

        // jal x1,8
        issue(32'h008000EF, 32'h0000_0210, 32'd0, 32'd0);
        wait_done("jal");
        check_val("jal_imm", imm, 32'd8);
        check_val("jal_class", 32'(instr_class), 32'h002);
        check_val("jal_wr", 32'(writes_rd), 32'd1);

        // srai x3,x3,4: shamt-only immediate, funct7 bit 5 set
        issue(32'h4041D193, 32'h0000_0214, 32'd0, 32'd0);
        wait_done("srai");
        check_val("srai_imm", imm, 32'd4);
        check_val("srai_f7b5", 32'(funct7_b5), 32'd1);
        check_val("srai_funct3", 32'(funct3), 32'd5);

        // all-zero word is illegal
        issue(32'h00000000, 32'h0000_0218, 32'd0, 32'd0);
        wait_done("zero");
        check_val("zero_class", 32'(instr_class), 32'h400);
        check_val("zero_imm", imm, 32'd0);
        check_val("zero_wr", 32'(writes_rd), 32'd0);

        // addi x0,x0,0 never writes
        issue(32'h00000013, 32'h0000_021C, 32'd0, 32'd0);
        wait_done("nop");
        check_val("nop_wr", 32'(writes_rd), 32'd0);
        check_val("nop_class", 32'(instr_class), 32'h040);

        // Re-enable one cycle into an operation: only the second word completes
        issue(32'h00500093, 32'h0000_0300, 32'd0, 32'd0);
        instr_raw = 32'h123452B7; pc = 32'h0000_0304; enabled = 1'b1;
        @(negedge clk);
        enabled = 1'b0;
        #1 check_val("reen_c1", 32'(completed), 32'd0);
        @(negedge clk);
        check_val("reen_c2", 32'(completed), 32'd0);
        @(negedge clk);
        check_val("reen_c3", 32'(completed), 32'd1);
        check_val("reen_pc_n", pc_n, 32'h0000_0304);
        check_val("reen_imm", imm, 32'h12345000);
        check_val("reen_rd", 32'(rd), 32'd5);
        $display("op reenable instr=0x%08h imm=0x%08h", instr_raw, imm);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
